// File: rtl/ddr2_pkg.sv
// ddr2_pkg: shared DDR2 command encodings, arbiter state type and command bus record
package ddr2_pkg;
    // Commands are {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam int DDR_ADDR_BITS = 14;
    localparam int DDR_BA_BITS   = 3;
    typedef enum logic [2:0] {ARB_INIT, ARB_IDLE, ARB_REF, ARB_WR, ARB_RD} arb_state_t;
    typedef struct packed {
        logic [3:0]               cmd;
        logic [DDR_ADDR_BITS-1:0] addr;
        logic [DDR_BA_BITS-1:0]   ba;
    } ddr_bus_t;
endpackage

// File: rtl/ddr2_cmd_arbiter_if.sv
// ddr2_cmd_arbiter_if: engine request/grant handshakes, engine buses and the PHY command bus
//   slave  : arbiter side (engine buses in, grants/status/PHY bus out)
//   master : engine/PHY side (the mirror image)
interface ddr2_cmd_arbiter_if #(
    parameter int ADDR_BITS = 14,
    parameter int BA_BITS   = 3
);
    logic                 init_end;
    logic [3:0]           init_cmd;
    logic [ADDR_BITS-1:0] init_addr;
    logic [BA_BITS-1:0]   init_ba;
    logic                 ref_grant;
    logic                 ref_done;
    logic [3:0]           ref_cmd;
    logic [ADDR_BITS-1:0] ref_addr;
    logic [BA_BITS-1:0]   ref_ba;
    logic                 wr_req;
    logic                 wr_grant;
    logic                 wr_done;
    logic [3:0]           wr_cmd;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [BA_BITS-1:0]   wr_ba;
    logic                 rd_req;
    logic                 rd_grant;
    logic                 rd_done;
    logic [3:0]           rd_cmd;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [BA_BITS-1:0]   rd_ba;
    logic                 ref_urgent;
    logic                 ref_ovf;
    logic [3:0]           ddr_cmd;
    logic [ADDR_BITS-1:0] ddr_addr;
    logic [BA_BITS-1:0]   ddr_ba;
    modport slave (
        input  init_end, init_cmd, init_addr, init_ba,
        input  ref_done, ref_cmd, ref_addr, ref_ba,
        input  wr_req, wr_done, wr_cmd, wr_addr, wr_ba,
        input  rd_req, rd_done, rd_cmd, rd_addr, rd_ba,
        output ref_grant, wr_grant, rd_grant, ref_urgent, ref_ovf,
        output ddr_cmd, ddr_addr, ddr_ba
    );
    modport master (
        output init_end, init_cmd, init_addr, init_ba,
        output ref_done, ref_cmd, ref_addr, ref_ba,
        output wr_req, wr_done, wr_cmd, wr_addr, wr_ba,
        output rd_req, rd_done, rd_cmd, rd_addr, rd_ba,
        input  ref_grant, wr_grant, rd_grant, ref_urgent, ref_ovf,
        input  ddr_cmd, ddr_addr, ddr_ba
    );
endinterface

// File: rtl/ddr2_ref_timer.sv
// ddr2_ref_timer: tREFI interval counter with saturating pending-refresh count
//   ck, rst_n  : clock, async active-low reset
//   en         : timer runs (arbiter out of init)
//   dec        : one pending refresh was serviced
//   ref_pend   : refreshes owed, saturates at REF_PEND_MAX
//   ref_urgent : ref_pend at saturation
//   ref_ovf    : sticky, an interval elapsed with nowhere to record it
module ddr2_ref_timer #(
    parameter int TREFI_CYC    = 1560,
    parameter int REF_PEND_MAX = 7
) (
    input  logic                              ck,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic                              dec,
    output logic [$clog2(REF_PEND_MAX+1)-1:0] ref_pend,
    output logic                              ref_urgent,
    output logic                              ref_ovf
);
    localparam int PW = $clog2(REF_PEND_MAX + 1);
    localparam int CW = $clog2(TREFI_CYC);
    logic [CW-1:0] cnt;
    logic          wrap;
    logic          sat;
    assign wrap       = en && (cnt == CW'(TREFI_CYC - 1));
    assign sat        = ref_pend == PW'(REF_PEND_MAX);
    assign ref_urgent = sat;
    // A wrap coinciding with a serviced refresh nets to zero even at saturation
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            ref_pend <= '0;
            ref_ovf  <= 1'b0;
        end else begin
            if (en) cnt <= wrap ? '0 : cnt + 1'b1;
            ref_pend <= ref_pend + PW'(wrap && (!sat || dec)) - PW'(dec && ref_pend != '0);
            if (wrap && sat && !dec) ref_ovf <= 1'b1;
        end
    end
endmodule

// File: rtl/ddr2_cmd_arbiter.sv
// ddr2_cmd_arbiter: owns the DDR2 command bus, init first, then refresh > write/read round-robin
//   ck, rst_n : controller clock, async active-low reset
//   bus       : slave modport carrying init/ref/wr/rd engine buses, grants,
//               refresh status and the registered PHY command bus
module ddr2_cmd_arbiter
    import ddr2_pkg::*;
#(
    parameter int ADDR_BITS    = DDR_ADDR_BITS,
    parameter int BA_BITS      = DDR_BA_BITS,
    parameter int TREFI_CYC    = 1560,
    parameter int REF_PEND_MAX = 7
) (
    input  logic                ck,
    input  logic                rst_n,
    ddr2_cmd_arbiter_if.slave   bus
);
    arb_state_t                          state;
    logic                                last_wr;
    logic [$clog2(REF_PEND_MAX+1)-1:0]   ref_pend;
    logic [3:0]                          src_cmd;
    logic [ADDR_BITS-1:0]                src_addr;
    logic [BA_BITS-1:0]                  src_ba;
    ddr2_ref_timer #(
        .TREFI_CYC    (TREFI_CYC),
        .REF_PEND_MAX (REF_PEND_MAX)
    ) u_tmr (
        .ck         (ck),
        .rst_n      (rst_n),
        .en         (state != ARB_INIT),
        .dec        (state == ARB_REF && bus.ref_done),
        .ref_pend   (ref_pend),
        .ref_urgent (bus.ref_urgent),
        .ref_ovf    (bus.ref_ovf)
    );
    // Idle drives NOP but holds addr/ba to avoid needless pin toggling
    always_comb begin
        src_cmd  = state == ARB_INIT ? bus.init_cmd  : state == ARB_REF ? bus.ref_cmd  :
                   state == ARB_WR   ? bus.wr_cmd    : state == ARB_RD  ? bus.rd_cmd   : CMD_NOP;
        src_addr = state == ARB_INIT ? bus.init_addr : state == ARB_REF ? bus.ref_addr :
                   state == ARB_WR   ? bus.wr_addr   : state == ARB_RD  ? bus.rd_addr  : bus.ddr_addr;
        src_ba   = state == ARB_INIT ? bus.init_ba   : state == ARB_REF ? bus.ref_ba   :
                   state == ARB_WR   ? bus.wr_ba     : state == ARB_RD  ? bus.rd_ba    : bus.ddr_ba;
    end
    // Every owner returns through IDLE, which guarantees one NOP between owners
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ARB_INIT;
            last_wr       <= 1'b0;
            bus.ref_grant <= 1'b0;
            bus.wr_grant  <= 1'b0;
            bus.rd_grant  <= 1'b0;
            bus.ddr_cmd   <= CMD_NOP;
            bus.ddr_addr  <= '0;
            bus.ddr_ba    <= '0;
        end else begin
            bus.ddr_cmd  <= src_cmd;
            bus.ddr_addr <= src_addr;
            bus.ddr_ba   <= src_ba;
            case (state)
                ARB_INIT: if (bus.init_end) state <= ARB_IDLE;
                ARB_IDLE:
                    if (ref_pend != '0) begin
                        state         <= ARB_REF;
                        bus.ref_grant <= 1'b1;
                    end else if (bus.wr_req && (!bus.rd_req || !last_wr)) begin
                        state        <= ARB_WR;
                        bus.wr_grant <= 1'b1;
                    end else if (bus.rd_req) begin
                        state        <= ARB_RD;
                        bus.rd_grant <= 1'b1;
                    end
                ARB_REF:
                    if (bus.ref_done) begin
                        state         <= ARB_IDLE;
                        bus.ref_grant <= 1'b0;
                    end
                ARB_WR:
                    if (bus.wr_done) begin
                        state        <= ARB_IDLE;
                        bus.wr_grant <= 1'b0;
                        last_wr      <= 1'b1;
                    end
                ARB_RD:
                    if (bus.rd_done) begin
                        state        <= ARB_IDLE;
                        bus.rd_grant <= 1'b0;
                        last_wr      <= 1'b0;
                    end
                default: state <= ARB_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr2_cmd_arbiter.sv
// tb_ddr2_cmd_arbiter: directed vector table, refresh saturation, random traffic and async reset checks
module tb_ddr2_cmd_arbiter;
    import ddr2_pkg::*;
    localparam int TREFI   = 20;
    localparam int REF_MAX = 7;
    logic ck = 1'b0;
    logic rst_n = 1'b1;
    int tests = 0;
    int fails = 0;
    always #5 ck = ~ck;
    ddr2_cmd_arbiter_if #(.ADDR_BITS(14), .BA_BITS(3)) bus ();
    ddr2_cmd_arbiter #(.TREFI_CYC(TREFI), .REF_PEND_MAX(REF_MAX)) dut (
        .ck    (ck),
        .rst_n (rst_n),
        .bus   (bus)
    );
    // Reference model: who owns the bus, refreshes owed, interval progress
    arb_state_t ms;
    int         mt;
    int         mp;
    bit         movf;
    bit         mlast;
    ddr_bus_t   mddr;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic model_reset();
        ms = ARB_INIT; mt = 0; mp = 0; movf = 0; mlast = 0;
        mddr = {CMD_NOP, 14'd0, 3'd0};
    endtask
    task automatic model_edge();
        ddr_bus_t   src;
        bit         wrap;
        bit         dec;
        int         p;
        arb_state_t nx;
        case (ms)
            ARB_INIT: src = {bus.init_cmd, bus.init_addr, bus.init_ba};
            ARB_REF:  src = {bus.ref_cmd, bus.ref_addr, bus.ref_ba};
            ARB_WR:   src = {bus.wr_cmd, bus.wr_addr, bus.wr_ba};
            ARB_RD:   src = {bus.rd_cmd, bus.rd_addr, bus.rd_ba};
            default:  src = {CMD_NOP, mddr.addr, mddr.ba};
        endcase
        wrap = (ms != ARB_INIT) && (mt == TREFI - 1);
        dec  = (ms == ARB_REF) && bus.ref_done;
        nx   = ms;
        case (ms)
            ARB_INIT: if (bus.init_end) nx = ARB_IDLE;
            ARB_IDLE:
                if (mp > 0) nx = ARB_REF;
                else if (bus.wr_req && bus.rd_req) nx = mlast ? ARB_RD : ARB_WR;
                else if (bus.wr_req) nx = ARB_WR;
                else if (bus.rd_req) nx = ARB_RD;
            ARB_REF: if (bus.ref_done) nx = ARB_IDLE;
            ARB_WR:  if (bus.wr_done) begin nx = ARB_IDLE; mlast = 1; end
            ARB_RD:  if (bus.rd_done) begin nx = ARB_IDLE; mlast = 0; end
            default: ;
        endcase
        if (ms != ARB_INIT) mt = wrap ? 0 : mt + 1;
        p = mp + int'(wrap) - int'(dec);
        if (p > REF_MAX) begin
            p = REF_MAX;
            movf = 1;
        end
        mp = p; ms = nx; mddr = src;
    endtask
    task automatic check_model();
        chk("grants", {bus.ref_grant, bus.wr_grant, bus.rd_grant},
            {ms == ARB_REF, ms == ARB_WR, ms == ARB_RD});
        chk("ddr_bus", {bus.ddr_cmd, bus.ddr_addr, bus.ddr_ba}, mddr);
        chk("ref_status", {bus.ref_urgent, bus.ref_ovf, dut.u_tmr.ref_pend},
            {mp == REF_MAX, movf, 3'(mp)});
    endtask
    task automatic step();
        @(posedge ck);
        model_edge();
        #1;
        check_model();
    endtask
    task automatic drive(input logic [5:0] v);
        {bus.init_end, bus.wr_req, bus.rd_req, bus.wr_done, bus.rd_done, bus.ref_done} = v;
    endtask
    typedef struct {
        logic [5:0] in;   // {init_end, wr_req, rd_req, wr_done, rd_done, ref_done}
        logic [2:0] g;    // {ref_grant, wr_grant, rd_grant}
        logic [3:0] cmd;
    } vec_t;
    vec_t tv[32];
    initial begin
        for (int i = 0; i < 5; i++) tv[i] = '{6'b000000, 3'b000, CMD_ACT};
        tv[5]  = '{6'b110000, 3'b000, CMD_ACT};
        tv[6]  = '{6'b010000, 3'b010, CMD_NOP};
        tv[7]  = '{6'b010010, 3'b010, CMD_WR};
        tv[8]  = '{6'b000100, 3'b000, CMD_WR};
        tv[9]  = '{6'b000000, 3'b000, CMD_NOP};
        tv[10] = '{6'b011000, 3'b001, CMD_NOP};
        tv[11] = '{6'b011000, 3'b001, CMD_RD};
        tv[12] = '{6'b011001, 3'b001, CMD_RD};
        tv[13] = '{6'b011000, 3'b001, CMD_RD};
        tv[14] = '{6'b011010, 3'b000, CMD_RD};
        tv[15] = '{6'b011000, 3'b010, CMD_NOP};
        for (int i = 16; i < 19; i++) tv[i] = '{6'b011000, 3'b010, CMD_WR};
        tv[19] = '{6'b011100, 3'b000, CMD_WR};
        tv[20] = '{6'b011000, 3'b001, CMD_NOP};
        for (int i = 21; i < 24; i++) tv[i] = '{6'b011000, 3'b001, CMD_RD};
        tv[24] = '{6'b011010, 3'b000, CMD_RD};
        tv[25] = '{6'b000000, 3'b000, CMD_NOP};
        tv[26] = '{6'b010000, 3'b100, CMD_NOP};
        tv[27] = '{6'b010000, 3'b100, CMD_REF};
        tv[28] = '{6'b010001, 3'b000, CMD_REF};
        tv[29] = '{6'b010000, 3'b010, CMD_NOP};
        tv[30] = '{6'b000100, 3'b000, CMD_WR};
        tv[31] = '{6'b000000, 3'b000, CMD_NOP};
        drive(6'b0);
        bus.init_cmd = CMD_ACT; bus.init_addr = 14'h11; bus.init_ba = 3'd1;
        bus.ref_cmd  = CMD_REF; bus.ref_addr  = 14'h44; bus.ref_ba  = 3'd4;
        bus.wr_cmd   = CMD_WR;  bus.wr_addr   = 14'h22; bus.wr_ba   = 3'd2;
        bus.rd_cmd   = CMD_RD;  bus.rd_addr   = 14'h33; bus.rd_ba   = 3'd3;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        chk("rst_grants", {bus.ref_grant, bus.wr_grant, bus.rd_grant}, 0);
        chk("rst_ddr", {bus.ddr_cmd, bus.ddr_addr, bus.ddr_ba}, {CMD_NOP, 17'd0});
        chk("rst_ref", {bus.ref_urgent, bus.ref_ovf, dut.u_tmr.ref_pend}, 0);
        chk("rst_state", dut.state, ARB_INIT);
        repeat (2) @(posedge ck);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            drive(tv[i].in);
            step();
            chk($sformatf("vec%0d_grants", i), {bus.ref_grant, bus.wr_grant, bus.rd_grant}, tv[i].g);
            chk($sformatf("vec%0d_cmd", i), bus.ddr_cmd, tv[i].cmd);
            if (i == 4) chk("timer_frozen_in_init", dut.u_tmr.cnt, 0);
        end
        chk("ref_pend_cleared", dut.u_tmr.ref_pend, 0);
        drive(6'b0);
        for (int i = 0; i < 160; i++) step();
        chk("sat_pend", dut.u_tmr.ref_pend, 7);
        chk("sat_urgent", bus.ref_urgent, 1);
        chk("sat_ovf", bus.ref_ovf, 1);
        chk("sat_ref_grant", bus.ref_grant, 1);
        drive(6'b000001);
        step();
        chk("sat_dec_pend", dut.u_tmr.ref_pend, 6);
        chk("sat_dec_urgent", bus.ref_urgent, 0);
        chk("sat_dec_grant", bus.ref_grant, 0);
        for (int i = 0; i < 600; i++) begin
            bus.init_end = 1'($urandom);
            bus.wr_req   = 1'($urandom);
            bus.rd_req   = 1'($urandom);
            bus.wr_done  = $urandom_range(3) == 0;
            bus.rd_done  = $urandom_range(3) == 0;
            bus.ref_done = $urandom_range(3) == 0;
            bus.init_cmd = 4'($urandom); bus.init_addr = 14'($urandom); bus.init_ba = 3'($urandom);
            bus.ref_cmd  = 4'($urandom); bus.ref_addr  = 14'($urandom); bus.ref_ba  = 3'($urandom);
            bus.wr_cmd   = 4'($urandom); bus.wr_addr   = 14'($urandom); bus.wr_ba   = 3'($urandom);
            bus.rd_cmd   = 4'($urandom); bus.rd_addr   = 14'($urandom); bus.rd_ba   = 3'($urandom);
            step();
        end
        drive(6'b0);
        bus.wr_cmd = CMD_WR;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model();
        rst_n = 1'b1;
        drive(6'b100000);
        step();
        drive(6'b010000);
        step();
        step();
        chk("pre_rst_wr_grant", bus.wr_grant, 1);
        chk("pre_rst_cmd", bus.ddr_cmd, CMD_WR);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_grant", bus.wr_grant, 0);
        chk("mid_rst_cmd", bus.ddr_cmd, CMD_NOP);
        chk("mid_rst_state", dut.state, ARB_INIT);
        model_reset();
        rst_n = 1'b1;
        drive(6'b010000);
        bus.init_cmd = CMD_PRE;
        step();
        chk("post_rst_init_cmd", bus.ddr_cmd, CMD_PRE);
        chk("post_rst_no_grant", {bus.ref_grant, bus.wr_grant, bus.rd_grant}, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
